// File: rtl/spi_controller.sv
// spi_controller -- SPI mode-0 bus master for the register-file peripheral.
//
// Sends one 16-bit command {rw, addr[6:0], wdata[7:0]} per accepted start,
// MSB first, on SCLK/COPI/nCS. The bus is write-only: there is no CIPO, so
// read commands (rw=0) are shifted out and return nothing.
//
// Optional feature macro: SPI_CTRL_QUEUE_EN
//   defined   : a one-entry pending register accepts a command while a frame
//               is in flight; ready = ~pending_valid.
//   undefined : no pending register; ready = ~busy.
//
// Parameters
//   CLK_DIV  clk cycles per SCLK half-period (>=4)
//   CS_SETUP clk cycles from nCS falling to the first SCLK low phase (>=1)
//   CS_HOLD  clk cycles from the last SCLK fall to nCS rising (>=1)
//   GAP      minimum clk cycles nCS stays high between frames (>=1)
//
// Ports
//   i_clk    system clock
//   i_rst    asynchronous reset, active-high
//   i_start  command strobe, accepted when o_ready=1
//   i_rw     frame bit 15 (1 = write)
//   i_addr   frame bits 14:8
//   i_wdata  frame bits 7:0
//   o_ready  a command can be accepted this cycle
//   o_busy   frame in progress, from nCS low until the end of the gap
//   o_done   one-cycle pulse when a frame, including its gap, completes
//   o_sclk   SPI clock, idles low
//   o_copi   serial data out
//   o_ncs    chip select, active-low
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int GAP      = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_sclk,
  output logic       o_copi,
  output logic       o_ncs
);

  localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int T_A   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int T_MAX = (T_A > GAP + 1) ? T_A : GAP + 1;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [PW-1:0] PH_LAST    = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP - 1);
  // The gap timer runs one step past the gap so done can be shown while busy.
  localparam logic [TW-1:0] DONE_CNT   = TW'(GAP);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_frame, w_frame_nxt;
  logic [3:0]    r_bit, w_bit_nxt;
  logic [PW-1:0] r_phase, w_phase_nxt;
  logic [TW-1:0] r_tmr, w_tmr_nxt;
  logic          r_sclk, w_sclk_nxt;
  logic          r_copi, w_copi_nxt;
  logic          r_ncs, w_ncs_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;

  logic          w_ready;
  logic          w_accept;
  logic          w_launch;
  logic [15:0]   w_in_frame;
  logic [15:0]   w_launch_frame;

  assign w_in_frame = {i_rw, i_addr, i_wdata};

`ifdef SPI_CTRL_QUEUE_EN
  logic [15:0] r_pend, w_pend_nxt;
  logic        r_pend_valid, w_pend_valid_nxt;
  logic        w_consume;

  // The pending entry is consumed on the last gap cycle, so that slot is free again.
  assign w_consume = (r_state == ST_GAP) && (r_tmr == GAP_LAST) && r_pend_valid;
  assign w_ready   = ~r_pend_valid | w_consume;
`else
  assign w_ready   = ~r_busy;
`endif

  assign w_accept = i_start & w_ready;

  // Decide whether a new frame starts at the next edge, and from which source.
  always_comb begin
    w_launch       = 1'b0;
    w_launch_frame = w_in_frame;
`ifdef SPI_CTRL_QUEUE_EN
    if ((r_state == ST_IDLE) && r_pend_valid) begin
      w_launch       = 1'b1;
      w_launch_frame = r_pend;
    end else if (w_consume) begin
      w_launch       = 1'b1;
      w_launch_frame = r_pend;
    end else if ((r_state == ST_IDLE) && w_accept) begin
      w_launch       = 1'b1;
      w_launch_frame = w_in_frame;
    end else begin
      w_launch       = 1'b0;
      w_launch_frame = w_in_frame;
    end
`else
    if ((r_state == ST_IDLE) && w_accept) begin
      w_launch = 1'b1;
    end else begin
      w_launch = 1'b0;
    end
`endif
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_bit_nxt   = r_bit;
    w_phase_nxt = r_phase;
    w_tmr_nxt   = r_tmr;
    w_sclk_nxt  = r_sclk;
    w_copi_nxt  = r_copi;
    w_ncs_nxt   = r_ncs;
    w_busy_nxt  = r_busy;
    w_done_nxt  = (r_state == ST_GAP) && (r_tmr == GAP_LAST);

    if (w_launch) begin
      w_state_nxt = ST_SETUP;
      w_frame_nxt = w_launch_frame;
      w_bit_nxt   = 4'd15;
      w_phase_nxt = {PW{1'b0}};
      w_tmr_nxt   = {TW{1'b0}};
      w_sclk_nxt  = 1'b0;
      w_copi_nxt  = w_launch_frame[15];
      w_ncs_nxt   = 1'b0;
      w_busy_nxt  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_busy_nxt = 1'b0;
        end
        ST_SETUP: begin
          if (r_tmr == SETUP_LAST) begin
            w_state_nxt = ST_SHIFT;
            w_tmr_nxt   = {TW{1'b0}};
            w_phase_nxt = {PW{1'b0}};
          end else begin
            w_tmr_nxt   = r_tmr + TW'(1);
          end
        end
        ST_SHIFT: begin
          if (r_phase != PH_LAST) begin
            w_phase_nxt = r_phase + PW'(1);
          end else if (!r_sclk) begin
            w_sclk_nxt  = 1'b1;
            w_phase_nxt = {PW{1'b0}};
          end else if (r_bit == 4'd0) begin
            // Last high phase over: copi keeps frame[0] through the hold.
            w_sclk_nxt  = 1'b0;
            w_phase_nxt = {PW{1'b0}};
            w_state_nxt = ST_HOLD;
            w_tmr_nxt   = {TW{1'b0}};
          end else begin
            // copi moves to the next bit on the same edge that sclk falls.
            w_sclk_nxt  = 1'b0;
            w_phase_nxt = {PW{1'b0}};
            w_bit_nxt   = r_bit - 4'd1;
            w_copi_nxt  = r_frame[r_bit - 4'd1];
          end
        end
        ST_HOLD: begin
          if (r_tmr == HOLD_LAST) begin
            w_state_nxt = ST_GAP;
            w_tmr_nxt   = {TW{1'b0}};
            w_ncs_nxt   = 1'b1;
            w_copi_nxt  = 1'b0;
          end else begin
            w_tmr_nxt   = r_tmr + TW'(1);
          end
        end
        ST_GAP: begin
          if (r_tmr == DONE_CNT) begin
            w_state_nxt = ST_IDLE;
            w_tmr_nxt   = {TW{1'b0}};
            w_busy_nxt  = 1'b0;
          end else begin
            w_tmr_nxt   = r_tmr + TW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_tmr_nxt   = {TW{1'b0}};
          w_phase_nxt = {PW{1'b0}};
          w_sclk_nxt  = 1'b0;
          w_copi_nxt  = 1'b0;
          w_ncs_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer and bus output registers; reset idles the bus immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_frame <= 16'h0000;
      r_bit   <= 4'd0;
      r_phase <= {PW{1'b0}};
      r_tmr   <= {TW{1'b0}};
      r_sclk  <= 1'b0;
      r_copi  <= 1'b0;
      r_ncs   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_frame <= w_frame_nxt;
      r_bit   <= w_bit_nxt;
      r_phase <= w_phase_nxt;
      r_tmr   <= w_tmr_nxt;
      r_sclk  <= w_sclk_nxt;
      r_copi  <= w_copi_nxt;
      r_ncs   <= w_ncs_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef SPI_CTRL_QUEUE_EN
  // Pending slot: loaded by a start while a frame is active, cleared when launched.
  always_comb begin
    w_pend_nxt       = r_pend;
    w_pend_valid_nxt = r_pend_valid;
    if (w_accept && (r_state != ST_IDLE)) begin
      w_pend_nxt       = w_in_frame;
      w_pend_valid_nxt = 1'b1;
    end else if (w_launch && r_pend_valid) begin
      w_pend_valid_nxt = 1'b0;
    end else begin
      w_pend_valid_nxt = r_pend_valid;
    end
  end

  // Pending slot registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend       <= 16'h0000;
      r_pend_valid <= 1'b0;
    end else begin
      r_pend       <= w_pend_nxt;
      r_pend_valid <= w_pend_valid_nxt;
    end
  end
`endif

  assign o_ready = w_ready;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_sclk  = r_sclk;
  assign o_copi  = r_copi;
  assign o_ncs   = r_ncs;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: one instance at default timing and
// one at CLK_DIV=7, CS_SETUP=1, CS_HOLD=1, GAP=1. Frames are captured from
// the bus and compared with the command concatenation and timing formulas.
module tb_spi_controller;

  localparam int DIV0 = 4, SU0 = 4, HO0 = 4, GP0 = 8;
  localparam int DIV1 = 7, SU1 = 1, HO1 = 1, GP1 = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;

  logic ready0, busy0, done0, sclk0, copi0, ncs0;
  logic ready1, busy1, done1, sclk1, copi1, ncs1;
  logic [1:0] ready_a, busy_a, done_a, sclk_a, copi_a, ncs_a;

  assign ready_a = {ready1, ready0};
  assign busy_a  = {busy1, busy0};
  assign done_a  = {done1, done0};
  assign sclk_a  = {sclk1, sclk0};
  assign copi_a  = {copi1, copi0};
  assign ncs_a   = {ncs1, ncs0};

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(DIV0), .CS_SETUP(SU0), .CS_HOLD(HO0), .GAP(GP0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_rw(rw), .i_addr(addr), .i_wdata(wdata),
    .o_ready(ready0), .o_busy(busy0), .o_done(done0), .o_sclk(sclk0), .o_copi(copi0), .o_ncs(ncs0)
  );

  spi_controller #(.CLK_DIV(DIV1), .CS_SETUP(SU1), .CS_HOLD(HO1), .GAP(GP1)) u_dut_fast (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_rw(rw), .i_addr(addr), .i_wdata(wdata),
    .o_ready(ready1), .o_busy(busy1), .o_done(done1), .o_sclk(sclk1), .o_copi(copi1), .o_ncs(ncs1)
  );

  int nvec = 0;
  int nmis = 0;

  // Register file of the peripheral as seen from the bus, and its reference.
  logic [7:0] periph  [128];
  logic [7:0] ref_reg [128];

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] exp_bits;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send one command on instance d and verify the whole frame on the bus.
  task automatic send(input int d, input logic [15:0] cmd, input logic [15:0] exp_bits, input bit hammer);
    int div, su, ho, gp, waited;
    int ncs_low, nrise, nfall, done_at, ndone, run, perr, cerr;
    logic [15:0] bits;
    logic ps, pn, pc, s, n, c, dn, busy_d, ready_d, busy_after;
    div = (d == 0) ? DIV0 : DIV1;
    su  = (d == 0) ? SU0  : SU1;
    ho  = (d == 0) ? HO0  : HO1;
    gp  = (d == 0) ? GP0  : GP1;
    waited = 0;
    while (ready_a[d] !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_start", 32'(ready_a[d]), 32'd1);
    {rw, addr, wdata} = cmd;
    start[d] = 1'b1;
    ps = sclk_a[d]; pn = ncs_a[d]; pc = copi_a[d];
    ncs_low = 0; nrise = 0; nfall = 0; done_at = 0; ndone = 0;
    run = 0; perr = 0; cerr = 0; bits = 16'h0000;
    busy_d = 1'b0; ready_d = 1'b1; busy_after = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      s = sclk_a[d]; n = ncs_a[d]; c = copi_a[d]; dn = done_a[d];
      if (!n) ncs_low++;
      if (pn && !n) nfall++;
      if (!ps && s) begin
        if (run != ((nrise == 0) ? su + div : div)) perr++;
        nrise++;
        bits = {bits[14:0], c};
      end
      if (ps && !s && run != div) perr++;
      if (!pn && n && run != ho) perr++;
      if ((c != pc) && !(ps && !s) && (n == pn)) cerr++;
      if ((s != ps) || (pn && !n)) run = 1;
      else run++;
      if (dn) begin
        ndone++;
        if (done_at == 0) begin
          done_at = k;
          busy_d  = busy_a[d];
          ready_d = ready_a[d];
        end
      end
      if (done_at != 0 && k == done_at + 1) busy_after = busy_a[d];
      ps = s; pn = n; pc = c;
      if (hammer && ndone == 0) begin
        start[d] = 1'b1;
        {rw, addr, wdata} = 16'($urandom);
      end else begin
        start[d] = 1'b0;
      end
      if (done_at != 0 && k == done_at + 2) break;
    end
    start[d] = 1'b0;
    check("copi_bits", 32'(bits), 32'(exp_bits));
    check("sclk_rises", 32'(nrise), 32'd16);
    check("ncs_low_width", 32'(ncs_low), 32'(su + 32 * div + ho));
    check("ncs_falls", 32'(nfall), 32'd1);
    check("start_to_done", 32'(done_at), 32'(1 + su + 32 * div + ho + gp));
    check("done_pulses", 32'(ndone), 32'd1);
    check("phase_lengths", 32'(perr), 32'd0);
    check("copi_stability", 32'(cerr), 32'd0);
    check("busy_in_done", 32'(busy_d), 32'd1);
    check("busy_after_done", 32'(busy_after), 32'd0);
`ifndef SPI_CTRL_QUEUE_EN
    check("ready_in_done", 32'(ready_d), 32'd0);
`endif
    if (nrise == 16 && bits[15]) periph[bits[14:8]] = bits[7:0];
  endtask

  // Reference peripheral behaviour: a write command stores wdata at addr.
  task automatic ref_apply(input logic r, input logic [6:0] a, input logic [7:0] w);
    if (r) ref_reg[a] = w;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r;
    logic [6:0]  a;
    logic [7:0]  w;
    int          dn_seen;
    start = 2'b00; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
    for (int i = 0; i < 128; i++) begin
      periph[i]  = 8'h00;
      ref_reg[i] = 8'h00;
    end
    tbl[0] = '{1'b1, 7'h04, 8'hA5, 16'h84A5};
    tbl[1] = '{1'b1, 7'h00, 8'hFF, 16'h80FF};
    tbl[2] = '{1'b1, 7'h04, 8'h80, 16'h8480};
    tbl[3] = '{1'b0, 7'h7F, 8'h00, 16'h7F00};
    tbl[4] = '{1'b0, 7'h00, 8'h00, 16'h0000};
    tbl[5] = '{1'b0, 7'h55, 8'h3C, 16'h553C};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ncs",   32'(ncs0),   32'd1);
    check("rst_sclk",  32'(sclk0),  32'd0);
    check("rst_copi",  32'(copi0),  32'd0);
    check("rst_busy",  32'(busy0),  32'd0);
    check("rst_done",  32'(done0),  32'd0);
    check("rst_ready", 32'(ready0), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table of fixed commands, including the end-to-end register writes
    for (int i = 0; i < 6; i++) begin
      send(0, {tbl[i].rw, tbl[i].addr, tbl[i].wdata}, tbl[i].exp_bits, 1'b0);
      ref_apply(tbl[i].rw, tbl[i].addr, tbl[i].wdata);
    end
    check("en_reg_out_7_0", 32'(periph[0]), 32'h0000_00FF);
    check("pwm_duty_cycle", 32'(periph[4]), 32'h0000_0080);

`ifndef SPI_CTRL_QUEUE_EN
    // Start held every cycle with changing inputs while busy
    send(0, 16'h9A3C, 16'h9A3C, 1'b1);
    ref_apply(1'b1, 7'h1A, 8'h3C);
`endif

    // Randomised commands against the reference model
    for (int i = 0; i < 6; i++) begin
      r = 1'($urandom); a = 7'($urandom); w = 8'($urandom);
      send(0, {r, a, w}, {r, a, w}, 1'b0);
      ref_apply(r, a, w);
      check("periph_reg", 32'(periph[a]), 32'(ref_reg[a]));
    end

    // Timing sweep on the fast-parameter instance
    for (int i = 0; i < 3; i++) begin
      r = 1'($urandom); a = 7'($urandom); w = 8'($urandom);
      send(1, {r, a, w}, {r, a, w}, 1'b0);
    end

    // Mid-frame reset while bit 9 is being shifted, sclk high
    {rw, addr, wdata} = 16'hFFFF;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (57) @(negedge clk);
    check("pre_rst_sclk", 32'(sclk0), 32'd1);
    check("pre_rst_ncs",  32'(ncs0),  32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ncs",   32'(ncs0),   32'd1);
    check("mid_rst_sclk",  32'(sclk0),  32'd0);
    check("mid_rst_copi",  32'(copi0),  32'd0);
    check("mid_rst_busy",  32'(busy0),  32'd0);
    check("mid_rst_ready", 32'(ready0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    dn_seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done0 || !ncs0) dn_seen++;
    end
    check("no_done_after_rst", 32'(dn_seen), 32'd0);

`ifdef SPI_CTRL_QUEUE_EN
    begin
      logic [15:0] ca, cb;
      logic [31:0] bits2;
      int nr, nd, hi, nf, dat;
      logic ps, pn;
      ca = {1'b1, 15'($urandom)};
      cb = {1'b1, 15'($urandom)};
      {rw, addr, wdata} = ca;
      start[0] = 1'b1;
      @(negedge clk);
      {rw, addr, wdata} = cb;
      @(negedge clk);
      start[0] = 1'b0;
      check("q_ready_after_second", 32'(ready0), 32'd0);
      bits2 = 32'h0; nr = 0; nd = 0; hi = 0; nf = 1; dat = 0;
      ps = sclk0; pn = ncs0;
      for (int k = 0; k < 1000; k++) begin
        @(negedge clk);
        if (!ps && sclk0) begin nr++; bits2 = {bits2[30:0], copi0}; end
        if (pn && !ncs0) nf++;
        if (ncs0 && nf == 1 && nr > 0) hi++;
        if (done0) begin nd++; dat = k; end
        ps = sclk0; pn = ncs0;
        if (nd == 2 && k == dat + 2) break;
      end
      check("q_rises", 32'(nr), 32'd32);
      check("q_bits", bits2, {ca, cb});
      check("q_gap_high", 32'(hi), 32'(GP0));
      check("q_done_pulses", 32'(nd), 32'd2);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
